// File: rtl/stochastic_number_generator_if.sv
// Operand/result bundle between a stochastic number generator and its consumer.
// The consumer drives the magnitude; the generator returns the finished stream and its done flag.
interface stochastic_number_generator_if;
    logic [7:0]   a;
    logic [254:0] a_sbs;
    logic         done;

    modport master (
        output a,
        input  a_sbs,
        input  done
    );

    modport slave (
        input  a,
        output a_sbs,
        output done
    );
endinterface

// File: rtl/stochastic_number_generator.sv
// Purpose: serialises an 8-bit magnitude into a 255-bit unipolar stream by LFSR comparison.
// Latency: done rises on the 255th edge after reset release (1+255 edges on restart, SNG_RESTART_EN).
// Backpressure: none; the result holds until reset, or until a changes when SNG_RESTART_EN is defined.
module stochastic_number_generator #(
    parameter logic [7:0] lfsr_seed = 8'hB4
) (
    input  logic                           clk,
    input  logic                           rst,
    stochastic_number_generator_if.slave   sif
);

    // An all-zero Fibonacci LFSR would lock up, so a zero seed is remapped.
    localparam logic [7:0] SEED = (lfsr_seed == 8'h00) ? 8'h01 : lfsr_seed;
    localparam logic [7:0] LAST_IDX = 8'd254;

    typedef enum logic [0:0] {
        ST_GEN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [7:0]   lfsr_q, lfsr_d;
    logic [7:0]   idx_q, idx_d;
    logic [7:0]   a_lat_q, a_lat_d;
    logic [254:0] sbs_q, sbs_d;
    logic [7:0]   a_val;
    logic [7:0]   lfsr_next;

    assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_GEN;
            lfsr_q  <= SEED;
            idx_q   <= 8'd0;
            a_lat_q <= 8'd0;
            sbs_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            idx_q   <= idx_d;
            a_lat_q <= a_lat_d;
            sbs_q   <= sbs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        idx_d   = idx_q;
        a_lat_d = a_lat_q;
        sbs_d   = sbs_q;
        a_val   = a_lat_q;

        unique case (state_q)
            ST_GEN: begin
                // Bit 0 uses the live input so no idle latch cycle is needed.
                if (idx_q == 8'd0) begin
                    a_val   = sif.a;
                    a_lat_d = sif.a;
                end
                sbs_d[idx_q] = (lfsr_q <= a_val);
                lfsr_d       = lfsr_next;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end
            ST_DONE: begin
`ifdef SNG_RESTART_EN
                // The LFSR has wrapped back to SEED, so regeneration needs no reload.
                if (sif.a != a_lat_q) begin
                    state_d = ST_GEN;
                    sbs_d   = '0;
                    idx_d   = 8'd0;
                    a_lat_d = sif.a;
                end
`endif
            end
            default: state_d = ST_GEN;
        endcase
    end

    assign sif.a_sbs = sbs_q;
    assign sif.done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_stochastic_number_generator.sv
// Randomised and directed checks of the stochastic number generator against a stream model.
// Two instances (default seed and seed 1) share clock, reset and operand.
module tb_stochastic_number_generator;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    stochastic_number_generator_if sif  ();
    stochastic_number_generator_if sif1 ();

    assign sif1.a = sif.a;

    stochastic_number_generator u_dut (
        .clk (clk),
        .rst (rst),
        .sif (sif.slave)
    );

    stochastic_number_generator #(.lfsr_seed(8'h01)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .sif (sif1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [254:0] got, input logic [254:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Stream model: bit k is set when the k-th LFSR state (starting at the seed) is <= a.
    function automatic logic [254:0] model_stream(input logic [7:0] seed, input logic [7:0] av);
        logic [254:0] r;
        logic [7:0]   s;
        s = (seed == 8'h00) ? 8'h01 : seed;
        r = '0;
        for (int k = 0; k < 255; k++) begin
            r[k] = (s <= av);
            s    = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        end
        return r;
    endfunction

    task automatic start(input logic [7:0] av);
        @(negedge clk);
        rst   = 1'b0;
        sif.a = av;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Counts rising edges until done; 0 means the budget ran out.
    task automatic wait_done(output int edges);
        edges = 0;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk);
            #1;
            if (sif.done) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic check_stream(input string tag, input logic [7:0] av);
        check_eq({tag, "_pop"},   255'($countones(sif.a_sbs)),  255'(av));
        check_eq({tag, "_pop1"},  255'($countones(sif1.a_sbs)), 255'(av));
        check_eq({tag, "_bits"},  sif.a_sbs,  model_stream(8'hB4, av));
        check_eq({tag, "_bits1"}, sif1.a_sbs, model_stream(8'h01, av));
        check_eq({tag, "_done1"}, 255'(sif1.done), 255'(1));
    endtask

    task automatic run_plain(input string tag, input logic [7:0] av);
        int edges;
        start(av);
        wait_done(edges);
        check_eq({tag, "_lat"}, 255'(edges), 255'(255));
        check_stream(tag, av);
    endtask

    initial begin
        int            edges;
        logic [7:0]    rv;
        logic [254:0]  snap;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        sif.a    = 8'd0;

        @(negedge clk);
        @(negedge clk);
        check_eq("rst_sbs",  sif.a_sbs, '0);
        check_eq("rst_done", 255'(sif.done), 255'(0));

        run_plain("a0", 8'd0);
        check_eq("a0_zero", sif.a_sbs, '0);

        run_plain("a255", 8'd255);
        check_eq("a255_ones", sif.a_sbs, {255{1'b1}});

        run_plain("a128", 8'd128);
        check_eq("a128_differ", 255'(sif.a_sbs != sif1.a_sbs), 255'(1));

        // Input change mid-stream must be ignored.
        start(8'd200);
        repeat (10) @(posedge clk);
        #1 sif.a = 8'd3;
        wait_done(edges);
        check_eq("a200_lat", 255'(edges + 10), 255'(255));
        check_stream("a200", 8'd200);

        // Reset asserted mid-stream clears everything at once.
        start(8'd50);
        repeat (100) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_eq("abort_sbs",  sif.a_sbs, '0);
        check_eq("abort_done", 255'(sif.done), 255'(0));
        @(negedge clk);
        rst = 1'b1;
        wait_done(edges);
        check_eq("a50_lat", 255'(edges), 255'(255));
        check_stream("a50", 8'd50);

        // Result holds while a is unchanged.
        snap = sif.a_sbs;
        repeat (5) @(posedge clk);
        #1;
        check_eq("hold_sbs",  sif.a_sbs, snap);
        check_eq("hold_done", 255'(sif.done), 255'(1));

        for (int t = 0; t < 4; t++) begin
            rv = 8'($urandom_range(0, 255));
            run_plain($sformatf("rnd%0d", t), rv);
        end

`ifdef SNG_RESTART_EN
        run_plain("a10", 8'd10);
        #1 sif.a = 8'd20;
        @(posedge clk);
        #1;
        check_eq("rs_done_drop", 255'(sif.done), 255'(0));
        check_eq("rs_sbs_clear", sif.a_sbs, '0);
        wait_done(edges);
        check_eq("rs_lat", 255'(edges == 0 ? 0 : edges + 1), 255'(256));
        check_stream("a20", 8'd20);
`else
        run_plain("a10", 8'd10);
        snap = sif.a_sbs;
        #1 sif.a = 8'd20;
        repeat (5) @(posedge clk);
        #1;
        check_eq("oneshot_done", 255'(sif.done), 255'(1));
        check_eq("oneshot_sbs",  sif.a_sbs, snap);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
